// File: rtl/decode_issue_nw.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_issue_nw : N-way decode/issue with intra-bundle RAW splitting,
// bypassed multi-port register file and registered execute outputs. Rev 1.0
// ----------------------------------------------------------------------------
module decode_issue_nw #(
  parameter int         ISSUE_W = 2,
  parameter int         DATA_W  = 16,
  parameter int         NREG    = 8,
  parameter logic [3:0] BR_OP   = 4'hC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ISSUE_W-1:0]        in_lane_valid,
  input  logic [16*ISSUE_W-1:0]     in_instr,
  output logic [ISSUE_W-1:0]        out_valid,
  input  logic                      out_ready,
  output logic [4*ISSUE_W-1:0]      out_opcode,
  output logic [ISSUE_W-1:0]        out_imm_flag,
  output logic [3*ISSUE_W-1:0]      out_rd,
  output logic [DATA_W*ISSUE_W-1:0] out_op1,
  output logic [DATA_W*ISSUE_W-1:0] out_op2,
  output logic [DATA_W*ISSUE_W-1:0] out_branch_target,
  input  logic [ISSUE_W-1:0]        wb_en,
  input  logic [3*ISSUE_W-1:0]      wb_addr,
  input  logic [DATA_W*ISSUE_W-1:0] wb_data
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [DATA_W-1:0]  rf_q    [NREG];
  logic [15:0]        instr_q [ISSUE_W];
  logic [ISSUE_W-1:0] pend_q;

  logic [ISSUE_W-1:0] grp_d;
  logic [DATA_W-1:0]  op1_d [ISSUE_W];
  logic [DATA_W-1:0]  op2_d [ISSUE_W];
  logic [7:0]         wmask;
  logic               stop;
  logic               issue;

  function automatic logic writes_rd(input logic [3:0] op);
    return (op != 4'h0) && (op != BR_OP);
  endfunction

  assign in_ready = (pend_q == '0) && !flush;
  assign issue    = (pend_q != '0) && ((out_valid == '0) || out_ready) && !flush;

  // Group grows lane by lane; wmask tracks rd written by lanes already in it.
  always_comb begin
    grp_d = '0;
    wmask = '0;
    stop  = 1'b0;
    for (int j = 0; j < ISSUE_W; j++) begin
      if (pend_q[j] && !stop) begin
        if (wmask[instr_q[j][7:5]] || (!instr_q[j][11] && wmask[instr_q[j][4:2]])) begin
          stop = 1'b1;
        end else begin
          grp_d[j] = 1'b1;
          if (writes_rd(instr_q[j][15:12])) wmask[instr_q[j][10:8]] = 1'b1;
        end
      end
    end
  end

  // Operand read with bypass; later ports override earlier ones.
  always_comb begin
    for (int j = 0; j < ISSUE_W; j++) begin
      op1_d[j] = rf_q[instr_q[j][5 +: RW]];
      op2_d[j] = rf_q[instr_q[j][2 +: RW]];
      for (int p = 0; p < ISSUE_W; p++) begin
        if (wb_en[p] && (wb_addr[3*p +: RW] == instr_q[j][5 +: RW]))
          op1_d[j] = wb_data[DATA_W*p +: DATA_W];
        if (wb_en[p] && (wb_addr[3*p +: RW] == instr_q[j][2 +: RW]))
          op2_d[j] = wb_data[DATA_W*p +: DATA_W];
      end
      if (instr_q[j][11]) op2_d[j] = DATA_W'(instr_q[j][4:0]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREG; k++) rf_q[k] <= '0;
      for (int j = 0; j < ISSUE_W; j++) instr_q[j] <= '0;
      pend_q            <= '0;
      out_valid         <= '0;
      out_opcode        <= '0;
      out_imm_flag      <= '0;
      out_rd            <= '0;
      out_op1           <= '0;
      out_op2           <= '0;
      out_branch_target <= '0;
    end else begin
      for (int p = 0; p < ISSUE_W; p++) begin
        if (wb_en[p]) rf_q[wb_addr[3*p +: RW]] <= wb_data[DATA_W*p +: DATA_W];
      end
      if (flush) begin
        pend_q    <= '0;
        out_valid <= '0;
      end else if (issue) begin
        out_valid <= grp_d;
        pend_q    <= pend_q & ~grp_d;
        for (int j = 0; j < ISSUE_W; j++) begin
          out_opcode[4*j +: 4]                 <= instr_q[j][15:12];
          out_imm_flag[j]                      <= instr_q[j][11];
          out_rd[3*j +: 3]                     <= instr_q[j][10:8];
          out_op1[DATA_W*j +: DATA_W]          <= op1_d[j];
          out_op2[DATA_W*j +: DATA_W]          <= op2_d[j];
          out_branch_target[DATA_W*j +: DATA_W] <= DATA_W'(instr_q[j][10:0]);
        end
      end else begin
        if (out_ready) out_valid <= '0;
        // Accept cannot coincide with issue: it needs an empty buffer.
        if (in_valid && in_ready) begin
          for (int j = 0; j < ISSUE_W; j++) instr_q[j] <= in_instr[16*j +: 16];
          pend_q <= in_lane_valid;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/decode_issue_nw.md
# decode_issue_nw

Parametrised N-way decode/issue stage for the superscalar core. It accepts a bundle of ISSUE_W 16-bit instructions and splits the bundle on intra-bundle RAW hazards. It reads operands from an internal multi-ported register file with write-back bypass, and presents registered per-lane decoded operations to the execute stage under a valid/ready handshake with branch flush.

## Interface
- ISSUE_W, 2: lanes per bundle (1..4).
- DATA_W, 16: register/operand width (≥16).
- NREG, 8: register count; index width RW = clog2(NREG), ≤3 (instruction fields are 3 bits).
- BR_OP, 4'hC: opcode that does not write rd. Opcode 4'h0 (NOP) also does not write rd.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- flush  in  1  branch-taken flush.
- in_valid  in  1  bundle offered.
- in_ready  out  1  bundle accepted when in_valid&&in_ready.
- in_lane_valid  in  ISSUE_W  per-lane instruction present.
- in_instr  in  16*ISSUE_W  lane i at [16i+15:16i].
- out_valid  out  ISSUE_W  per-lane issued op.
- out_ready  in  1  execute accepts the whole output bundle.
- out_opcode  out  4*ISSUE_W  decoded opcode.
- out_imm_flag  out  ISSUE_W  immediate flag.
- out_rd  out  3*ISSUE_W  destination register.
- out_op1, out_op2  out  DATA_W*ISSUE_W  operands.
- out_branch_target  out  DATA_W*ISSUE_W  zero-extended instr[10:0].
- wb_en  in  ISSUE_W  write-back enables.
- wb_addr  in  3*ISSUE_W  write-back registers.
- wb_data  in  DATA_W*ISSUE_W  write-back data.

## Operation
- Field decode: opcode=[15:12], imm_flag=[11], rd=[10:8], rs1=[7:5], rs2=[4:2], imm=[4:0].
- op1 = RF[rs1]. op2 = imm_flag ? zero-extended imm : RF[rs2].
- A lane "writes" when its opcode is neither 0 nor BR_OP.
- Register file: NREG×DATA_W, all zero on reset. Written at posedge from wb ports.
  - Same-address collision: highest port index wins.
  - Reads bypass same-cycle writes, with the highest-index matching port winning.
- Bundle buffer: holds instructions plus pending mask pend[ISSUE_W].
  - in_ready = (pend==0) && !flush.
  - On accept: pend <= in_lane_valid.
- Issue condition: pend!=0 && (out_valid==0 || out_ready) && !flush.
- Issue group = maximal contiguous run of pending lanes, starting at the lowest pending lane, with two stop rules:
  - Stop before lane j if an earlier group lane writes rd equal to rs1_j.
  - Stop before lane j if an earlier group lane writes rd equal to rs2_j and imm_flag_j==0.
- Group lanes are registered to the outputs with out_valid set, and their pend bits are cleared. Non-group lanes have out_valid=0.
- Non-pending lanes inside the span (in_lane_valid holes) are skipped; they neither issue nor block.
- Output held: out_valid && !out_ready keeps all outputs stable. The buffer does not advance.
- Output consumed, no new issue: out_ready with no issue condition sets out_valid <= 0.
- Flush (highest priority after reset): pend <= 0, out_valid <= 0 at next edge, input ignored that cycle.
  - Register-file writes still occur during flush.

## Timing
- Reset (asynchronous): out_valid=0, all out_* data=0, pend=0, RF=0. in_ready=1 after reset deasserts unless flush.
- Latency: bundle accepted at edge T issues at edge T+1 (outputs visible after T+1) when unsplit and unstalled.
- Each hazard split adds one cycle. Worst case ISSUE_W cycles per bundle.
- Throughput: one unsplit bundle every 2 cycles, because in_ready requires an empty buffer.
- Operand sampling: RF is read in the issue cycle, including bypass of that cycle's wb.
- RF reads by a held output are not refreshed while stalled.
- Reset mid-operation: everything clears immediately. No partial bundle survives.
- Simultaneous flush and in_valid: bundle not accepted (in_ready=0).

## Test plan
- Reset, then RF writes R1=5 and R2=7 via wb. Bundle {ADD(op 1) r3,r1,r2 ; ADDI(op 2,imm) r4,r1,#3} → same cycle: lane0 op1=5, op2=7; lane1 op1=5, op2=3; out_valid=2'b11.
- RAW split: lane0 writes r3, lane1 reads r3 → cycle1 out_valid=2'b01; cycle2 out_valid=2'b10. in_ready stays 0 until pend clears.
- Bypass: wb_en writes R5=16'hABCD in the same cycle lane0 issues with rs1=5 → op1=16'hABCD. Both ports write R5 → port1 data observed.
- Backpressure: out_ready=0 for 3 cycles → outputs stable, no pend change. Release → next bundle issues.
- Flush while a split bundle has one lane pending → next edge out_valid=0, pend=0, in_ready=1. The remaining lane never issues.
- Branch opcode BR_OP with rd=3 followed by a lane reading r3 → no split. out_branch_target = instr[10:0] zero-extended.
